// File: rtl/aes128_key_expand_if.sv
// Handshake bundle between the AES-128 key scheduler and its consumer.
// The master issues start/key and accepts round keys; the slave is the scheduler.
interface aes128_key_expand_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  modport master (
    output start, key, rk_ready,
    input  busy, rk_valid, round_key, round_idx, done
  );

  modport slave (
    input  start, key, rk_ready,
    output busy, rk_valid, round_key, round_idx, done
  );
endinterface

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: emits round keys 0..NR as a valid/ready
// stream, one combinationally derived round key per accepted beat.

// Byte S-box: GF(2^8) multiplicative inverse (x^254) followed by the AES affine map.
module sbox_v2 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] s;
    logic [7:0] m;
    p = '0;
    s = x;
    m = z;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
      m = {1'b0, m[7:1]};
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h01;
    s = x;
    for (int unsigned i = 0; i < 7; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction

  logic [7:0] inv;

  assign inv = ginv(a);
  assign y   = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
endmodule

module aes128_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes128_key_expand_if.slave   bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [3:0] LAST = 4'(NR);

  logic [0:0]   state;
  logic         busy_q;
  logic         valid_q;
  logic         done_q;
  logic [127:0] rk_q;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] rk_next;
  logic [7:0]   rcon_next;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox_v2 u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign t         = sub ^ {rcon_q, 24'h000000};
  assign w0n       = w0 ^ t;
  assign w1n       = w1 ^ w0n;
  assign w2n       = w2 ^ w1n;
  assign w3n       = w3 ^ w2n;
  assign rk_next   = {w0n, w1n, w2n, w3n};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rk_q    <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rk_q    <= bus.key;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (bus.rk_ready) begin
            // Final beat leaves key/index as-is so the consumer can still observe them.
            if (idx_q == LAST) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end else begin
              rk_q   <= rk_next;
              idx_q  <= idx_q + 4'd1;
              rcon_q <= rcon_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.rk_valid  = valid_q;
  assign bus.done      = done_q;
  assign bus.round_key = rk_q;
  assign bus.round_idx = idx_q;
endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand: FIPS-197 word-level key expansion
// model compared against the DUT outputs on every cycle, plus directed scenarios.
module tb_aes128_key_expand;
  localparam logic [127:0] FIPS     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  aes128_key_expand_if bus ();

  aes128_key_expand #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit ready_rand = 1'b0;

  logic [7:0] sb [0:255];
  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box table via the generator-3 walk over GF(2^8)*, independent of the DUT's inversion.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Round key r from the FIPS-197 word recurrence w[i] = w[i-4] ^ f(w[i-1]).
  function automatic logic [127:0] ref_rk(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 4*r + 4; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]}
            ^ {rcon_tab[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Transaction-level model of the stream the consumer must see.
  bit           m_busy  = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_done  = 1'b0;
  int           m_idx   = 0;
  logic [127:0] m_key    = '0;
  logic [127:0] m_cipher = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_idx = 0; m_key = '0;
    end else begin
      m_done = 1'b0;
      if (!m_valid) begin
        if (bus.start) begin
          m_cipher = bus.key; m_key = bus.key; m_idx = 0;
          m_valid = 1'b1; m_busy = 1'b1;
        end
      end else if (bus.rk_ready) begin
        if (m_idx == 10) begin
          m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_idx++;
          m_key = ref_rk(m_cipher, m_idx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle{busy,valid,done,idx,key}",
            {1'b0, bus.busy, bus.rk_valid, bus.done, bus.round_idx, bus.round_key},
            {1'b0, m_busy, m_valid, m_done, 4'(m_idx), m_key});
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready_rand) bus.rk_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic kick(input logic [127:0] k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = k;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = rand_key();
  endtask

  task automatic wait_idx(input int idx);
    for (int n = 0; n < 300; n++) begin
      if (bus.rk_valid && bus.round_idx == 4'(idx)) return;
      @(negedge clk);
    end
    n_vec++; n_err++;
    $display("FAIL wait_idx%0d: beat never appeared, expected within 300 cycles", idx);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 600; n++) begin
      if (bus.done) return;
      @(negedge clk);
    end
    n_vec++; n_err++;
    $display("FAIL wait_done: done never pulsed, expected within 600 cycles");
  endtask

  initial begin
    int cyc;
    logic [127:0] k;
    bus.start = 1'b0; bus.key = '0; bus.rk_ready = 1'b1;
    build_sbox();

    check("model_sbox_00", {128'h0, sb[8'h00]}, {128'h0, 8'h63});
    check("model_sbox_53", {128'h0, sb[8'h53]}, {128'h0, 8'hed});
    check("model_fips_r1",  {8'h0, ref_rk(FIPS, 1)},   {8'h0, FIPS_R1});
    check("model_fips_r10", {8'h0, ref_rk(FIPS, 10)},  {8'h0, FIPS_R10});
    check("model_zero_r1",  {8'h0, ref_rk('0, 1)},     {8'h0, ZERO_R1});
    check("model_zero_r10", {8'h0, ref_rk('0, 10)},    {8'h0, ZERO_R10});

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_state", {1'b0, bus.busy, bus.rk_valid, bus.done, bus.round_idx, bus.round_key}, '0);

    // FIPS-197 vector with latency measurement.
    @(negedge clk);
    bus.start = 1'b1; bus.key = FIPS;
    @(negedge clk);
    bus.start = 1'b0; bus.key = rand_key();
    cyc = 1;
    check("fips_idx0", {3'b0, bus.rk_valid, bus.round_idx, bus.round_key}, {3'b0, 1'b1, 4'd0, FIPS});
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.rk_valid && bus.round_idx == 4'd1) check("fips_idx1", {8'h0, bus.round_key}, {8'h0, FIPS_R1});
      if (bus.rk_valid && bus.round_idx == 4'd10) check("fips_idx10", {8'h0, bus.round_key}, {8'h0, FIPS_R10});
    end
    check("done_latency", 136'(cyc), 136'd12);

    // All-zero key.
    kick('0);
    wait_idx(1);
    check("zero_idx1", {8'h0, bus.round_key}, {8'h0, ZERO_R1});
    wait_idx(10);
    check("zero_idx10", {8'h0, bus.round_key}, {8'h0, ZERO_R10});
    wait_done();

    // Backpressure at idx 4.
    kick(FIPS);
    wait_idx(4);
    bus.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_hold", {3'b0, bus.rk_valid, bus.round_idx, bus.round_key}, {3'b0, 1'b1, 4'd4, ref_rk(FIPS, 4)});
    bus.rk_ready = 1'b1;
    wait_idx(10);
    check("bp_idx10", {8'h0, bus.round_key}, {8'h0, FIPS_R10});
    wait_done();

    // Start while busy must be ignored.
    kick(FIPS);
    wait_idx(5);
    bus.start = 1'b1; bus.key = rand_key();
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_ignore", {135'h0, bus.busy}, {135'h0, 1'b1});
    wait_idx(10);
    check("busy_idx10", {8'h0, bus.round_key}, {8'h0, FIPS_R10});
    wait_done();

    // Asynchronous reset mid-expansion.
    kick(FIPS);
    wait_idx(6);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {1'b0, bus.busy, bus.rk_valid, bus.done, bus.round_idx, bus.round_key}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    k = rand_key();
    kick(k);
    check("post_reset_idx0", {3'b0, bus.rk_valid, bus.round_idx, bus.round_key}, {3'b0, 1'b1, 4'd0, k});
    @(negedge clk);
    check("post_reset_idx1", {4'b0, bus.round_idx, bus.round_key}, {4'b0, 4'd1, ref_rk(k, 1)});
    wait_done();

    // Back-to-back: start in the done cycle.
    kick(rand_key());
    wait_done();
    k = rand_key();
    bus.start = 1'b1; bus.key = k;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_idx0", {3'b0, bus.rk_valid, bus.round_idx, bus.round_key}, {3'b0, 1'b1, 4'd0, k});
    wait_done();

    // Random keys under random backpressure.
    ready_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      kick(rand_key());
      wait_done();
    end
    ready_rand = 1'b0;
    bus.rk_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
